// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver, LSB first, one stop bit (optional UART_RX_MAJORITY_EN: 2-of-3 centre voting)
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick_16x,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 sync_ff1;
    logic                 rxs;
    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [3:0]           cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS:0]   shift_wide;
    logic                 end_tick;
    logic                 centre_tick;
    logic                 centre_sample;

    // Last tick of a bit period: the counter is about to wrap.
    assign end_tick   = baud_tick_16x && (cnt == 4'd15);

    // New sample enters at the MSB so that after DATA_BITS shifts the first (LSB) bit sits at bit 0.
    assign shift_wide = {centre_sample, shift_reg};

`ifdef UART_RX_MAJORITY_EN
    logic samp6;
    logic samp7;

    // Decide on the cnt==8 tick using the samples from ticks 6, 7 and the live value at tick 8.
    assign centre_tick   = baud_tick_16x && (cnt == 4'd8);
    assign centre_sample = (samp6 & samp7) | (samp6 & rxs) | (samp7 & rxs);

    // Capture the two early votes; idle-high reset keeps a fresh start from voting low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp6 <= 1'b1;
            samp7 <= 1'b1;
        end else if (baud_tick_16x) begin
            if (cnt == 4'd6) samp6 <= rxs;
            if (cnt == 4'd7) samp7 <= rxs;
        end
    end
`else
    // Single sample taken on the 8th tick of the bit period.
    assign centre_tick   = baud_tick_16x && (cnt == 4'd7);
    assign centre_sample = rxs;
`endif

    // Two-flop synchronizer; both flops reset high so reset release looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            sync_ff1 <= rx_line;
            rxs      <= sync_ff1;
        end
    end

    // Next-state decode for the frame walker.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rxs) state_nxt = S_START;
            end
            S_START: begin
                if (centre_tick && centre_sample) state_nxt = S_IDLE;
                else if (end_tick)                state_nxt = S_DATA;
            end
            S_DATA: begin
                if (end_tick && (bit_idx == LAST_IDX)) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (centre_tick) state_nxt = centre_sample ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rxs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register with busy flag registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            rx_busy <= (state_nxt != S_IDLE);
        end
    end

    // Tick counter: held at zero while idle so a detected start edge begins a clean bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (state == S_IDLE) begin
            cnt <= 4'd0;
        end else if (baud_tick_16x) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Bit index and shift register for the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == S_START && end_tick) begin
                bit_idx <= '0;
            end else if (state == S_DATA && end_tick && (bit_idx != LAST_IDX)) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_DATA && centre_tick) begin
                shift_reg <= shift_wide[DATA_BITS:1];
            end
        end
    end

    // Stop-bit verdict: publish the word with a one-cycle strobe, or pulse a framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == S_STOP && centre_tick) begin
                if (centre_sample) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
